// File: rtl/axis_slave_rx.sv
// AXI4-Stream receive stage: FWFT buffer plus packet length tracking.
// Ports: aclk/areset, AXIS slave (tvalid/tlast/tdata/tready),
//        FIFO read side (rd_en/data/last/empty), packet status
//        (pkt_done/pkt_len/beat_cnt).
module axis_slave_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  tvalid_in,
  input  logic                  tlast_in,
  input  logic [DATA_WIDTH-1:0] tdata_in,
  output logic                  tready_out,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  output logic                  empty_out,
  output logic                  pkt_done_out,
  output logic [CNT_WIDTH-1:0]  pkt_len_out,
  output logic [CNT_WIDTH-1:0]  beat_cnt_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         count;

  state_t state_q;
  state_t state_d;

  logic accept;
  logic pop;
  logic [CNT_WIDTH-1:0] beat_inc;

  assign empty_out = (count == '0);

  // Depth is a power of two, so the top count bit
  // set means exactly FIFO_DEPTH entries held.
  assign tready_out = !areset && !count[AW];

  assign accept = tvalid_in && tready_out;
  assign pop    = rd_en_in && !empty_out;

  assign data_out = empty_out ? '0
                  : mem[rd_ptr][DATA_WIDTH-1:0];
  assign last_out = empty_out ? 1'b0
                  : mem[rd_ptr][DATA_WIDTH];

  // Saturating increment of the running beat count.
  assign beat_inc = (&beat_cnt_out) ? beat_cnt_out
                  : beat_cnt_out + CNT_WIDTH'(1);

  always_ff @(posedge aclk) begin
    if (accept) begin
      mem[wr_ptr] <= {tlast_in, tdata_in};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !tlast_in) begin
          state_d = IN_PKT;
        end
      end
      IN_PKT: begin
        if (accept && tlast_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt_out <= '0;
      pkt_len_out  <= '0;
      pkt_done_out <= 1'b0;
    end else begin
      pkt_done_out <= 1'b0;
      if (accept) begin
        if (tlast_in) begin
          pkt_len_out  <= beat_inc;
          pkt_done_out <= 1'b1;
          beat_cnt_out <= '0;
        end else begin
          beat_cnt_out <= beat_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_slave_rx.sv
// Directed bench for axis_slave_rx: vector table
// plus hand-written full/backpressure sequence.
module tb_axis_slave_rx;

  logic        aclk;
  logic        areset;
  logic        tvalid_in;
  logic        tlast_in;
  logic [31:0] tdata_in;
  logic        tready_out;
  logic        rd_en_in;
  logic [31:0] data_out;
  logic        last_out;
  logic        empty_out;
  logic        pkt_done_out;
  logic [15:0] pkt_len_out;
  logic [15:0] beat_cnt_out;

  int checks;
  int failures;

  axis_slave_rx #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .tvalid_in(tvalid_in),
    .tlast_in(tlast_in),
    .tdata_in(tdata_in),
    .tready_out(tready_out),
    .rd_en_in(rd_en_in),
    .data_out(data_out),
    .last_out(last_out),
    .empty_out(empty_out),
    .pkt_done_out(pkt_done_out),
    .pkt_len_out(pkt_len_out),
    .beat_cnt_out(beat_cnt_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        rst;
    logic        tv;
    logic        tl;
    logic [31:0] td;
    logic        rd;
    logic        rdy;
    logic        emp;
    logic [31:0] dat;
    logic        lst;
    logic        done;
    logic [15:0] len;
    logic [15:0] bcnt;
  } vec_t;

  vec_t v [26];

  function automatic vec_t mk(
    input logic        rst,
    input logic        tv,
    input logic        tl,
    input logic [31:0] td,
    input logic        rd,
    input logic        rdy,
    input logic        emp,
    input logic [31:0] dat,
    input logic        lst,
    input logic        done,
    input logic [15:0] len,
    input logic [15:0] bcnt
  );
    vec_t r;
    r.rst = rst; r.tv = tv; r.tl = tl;
    r.td = td; r.rd = rd;
    r.rdy = rdy; r.emp = emp; r.dat = dat;
    r.lst = lst; r.done = done;
    r.len = len; r.bcnt = bcnt;
    return r;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic        rst,
    input logic        tv,
    input logic        tl,
    input logic [31:0] td,
    input logic        rd
  );
    areset    = rst;
    tvalid_in = tv;
    tlast_in  = tl;
    tdata_in  = td;
    rd_en_in  = rd;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    areset    = 1'b1;
    tvalid_in = 1'b0;
    tlast_in  = 1'b0;
    tdata_in  = '0;
    rd_en_in  = 1'b0;

    // reset for two cycles, release
    v[0]  = mk(1,0,0,0,0,   0,1,0,0,0,0,0);
    v[1]  = mk(1,0,0,0,0,   0,1,0,0,0,0,0);
    v[2]  = mk(0,0,0,0,0,   1,1,0,0,0,0,0);
    // 4-beat packet, no pops
    v[3]  = mk(0,1,0,'hA0,0, 1,0,'hA0,0,0,0,1);
    v[4]  = mk(0,1,0,'hA1,0, 1,0,'hA0,0,0,0,2);
    v[5]  = mk(0,1,0,'hA2,0, 1,0,'hA0,0,0,0,3);
    v[6]  = mk(0,1,1,'hA3,0, 1,0,'hA0,0,1,4,0);
    v[7]  = mk(0,0,0,0,0,    1,0,'hA0,0,0,4,0);
    // pop to 3, then accept+pop together
    v[8]  = mk(0,0,0,0,1,    1,0,'hA1,0,0,4,0);
    v[9]  = mk(0,1,0,'hB0,1, 1,0,'hA2,0,0,4,1);
    // three pops drain exactly: count stayed 3
    v[10] = mk(0,0,0,0,1,    1,0,'hA3,1,0,4,1);
    v[11] = mk(0,0,0,0,1,    1,0,'hB0,0,0,4,1);
    v[12] = mk(0,0,0,0,1,    1,1,0,0,0,4,1);
    // pop while empty: nothing changes
    v[13] = mk(0,0,0,0,1,    1,1,0,0,0,4,1);
    // close packet B (2 beats)
    v[14] = mk(0,1,1,'hB1,0, 1,0,'hB1,1,1,2,0);
    v[15] = mk(0,0,0,0,1,    1,1,0,0,0,2,0);
    // single-beat packet from IDLE
    v[16] = mk(0,1,1,'hC0,0, 1,0,'hC0,1,1,1,0);
    v[17] = mk(0,0,0,0,1,    1,1,0,0,0,1,0);
    // reset after 2 of 4 beats
    v[18] = mk(0,1,0,'hD0,0, 1,0,'hD0,0,0,1,1);
    v[19] = mk(0,1,0,'hD1,0, 1,0,'hD0,0,0,1,2);
    v[20] = mk(1,0,0,0,0,    0,1,0,0,0,0,0);
    v[21] = mk(0,0,0,0,0,    1,1,0,0,0,0,0);
    // fresh 3-beat packet
    v[22] = mk(0,1,0,'hE0,0, 1,0,'hE0,0,0,0,1);
    v[23] = mk(0,1,0,'hE1,0, 1,0,'hE0,0,0,0,2);
    v[24] = mk(0,1,1,'hE2,0, 1,0,'hE0,0,1,3,0);
    v[25] = mk(0,0,0,0,0,    1,0,'hE0,0,0,3,0);

    for (int i = 0; i < 26; i++) begin
      drive(v[i].rst, v[i].tv, v[i].tl,
            v[i].td, v[i].rd);
      chk($sformatf("v%0d tready", i),
          32'(tready_out), 32'(v[i].rdy));
      chk($sformatf("v%0d empty", i),
          32'(empty_out), 32'(v[i].emp));
      chk($sformatf("v%0d data", i),
          data_out, v[i].dat);
      chk($sformatf("v%0d last", i),
          32'(last_out), 32'(v[i].lst));
      chk($sformatf("v%0d pkt_done", i),
          32'(pkt_done_out), 32'(v[i].done));
      chk($sformatf("v%0d pkt_len", i),
          32'(pkt_len_out), 32'(v[i].len));
      chk($sformatf("v%0d beat_cnt", i),
          32'(beat_cnt_out), 32'(v[i].bcnt));
    end

    // fill to full with tvalid held
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("fill start empty", 32'(empty_out), 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 32'h100 + i, 0);
      chk($sformatf("fill%0d tready", i),
          32'(tready_out), (i < 7) ? 1 : 0);
    end
    // 9th beat stalls
    drive(0, 1, 0, 32'h108, 0);
    chk("stall tready", 32'(tready_out), 0);
    chk("stall head", data_out, 32'h100);
    // one pop; tready rises next cycle only
    drive(0, 1, 0, 32'h108, 1);
    chk("pop tready", 32'(tready_out), 1);
    chk("pop head", data_out, 32'h101);
    // 9th beat accepted, full again
    drive(0, 1, 0, 32'h108, 0);
    chk("refill tready", 32'(tready_out), 0);
    tvalid_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d data", k),
          data_out, 32'h100 + k);
      drive(0, 0, 0, 0, 1);
    end
    chk("drain empty", 32'(empty_out), 1);
    chk("drain data zero", data_out, 0);
    chk("drain tready", 32'(tready_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
